// File: rtl/lcd_reader.sv
// HD44780 read-cycle engine: drives RS/RW/EN for one bus read (or a busy-flag
// poll loop) and reports the sampled byte, busy flag and address counter.
module lcd_reader #(
  parameter int T_AS     = 3,
  parameter int T_EN     = 25,
  parameter int T_EN_LOW = 25,
  parameter int POLL_MAX = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic       i_poll,
  output logic       o_busy,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_bf,
  output logic [6:0] o_addr,
  output logic       o_timeout,
  output logic       o_LCD_EN,
  output logic       o_LCD_RS,
  output logic       o_LCD_RW,
  input  logic [7:0] i_LCD_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HIGH,
    S_EN_LOW,
    S_DONE
  } state_t;

  localparam int CNT_MAX = (T_AS > T_EN) ? ((T_AS > T_EN_LOW) ? T_AS : T_EN_LOW)
                                         : ((T_EN > T_EN_LOW) ? T_EN : T_EN_LOW);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rs_q;
  logic             poll_q;
  logic [7:0]       sample_q;
  logic [7:0]       poll_cnt_q;

  logic last_as;
  logic last_en;
  logic last_low;
  logic poll_again;

  assign last_as  = (cnt_q == CNT_W'(T_AS - 1));
  assign last_en  = (cnt_q == CNT_W'(T_EN - 1));
  assign last_low = (cnt_q == CNT_W'(T_EN_LOW - 1));
  // Widened to 9 bits so poll_cnt+1 cannot wrap against POLL_MAX=255.
  assign poll_again = poll_q & sample_q[7] &
                      (({1'b0, poll_cnt_q} + 9'd1) < 9'(POLL_MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      sample_q   <= '0;
      poll_cnt_q <= '0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_bf       <= 1'b0;
      o_addr     <= '0;
      o_timeout  <= 1'b0;
      o_LCD_EN   <= 1'b0;
      o_LCD_RS   <= 1'b0;
      o_LCD_RW   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            rs_q       <= i_rs;
            poll_q     <= i_poll & ~i_rs;
            poll_cnt_q <= '0;
            cnt_q      <= '0;
            o_timeout  <= 1'b0;
            o_busy     <= 1'b1;
            o_LCD_RS   <= i_rs;
            o_LCD_RW   <= 1'b1;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (last_as) begin
            cnt_q    <= '0;
            o_LCD_EN <= 1'b1;
            state_q  <= S_EN_HIGH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EN_HIGH: begin
          if (last_en) begin
            sample_q <= i_LCD_data;
            cnt_q    <= '0;
            o_LCD_EN <= 1'b0;
            state_q  <= S_EN_LOW;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EN_LOW: begin
          if (last_low) begin
            cnt_q <= '0;
            if (poll_again) begin
              poll_cnt_q <= poll_cnt_q + 8'd1;
              state_q    <= S_SETUP;
            end else begin
              o_valid   <= 1'b1;
              o_data    <= sample_q;
              o_timeout <= poll_q & sample_q[7];
              if (!rs_q) begin
                o_bf   <= sample_q[7];
                o_addr <= sample_q[6:0];
              end
              o_LCD_RW <= 1'b0;
              o_LCD_RS <= 1'b0;
              state_q  <= S_DONE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader: a transaction-level model predicts each
// completion; a monitor compares o_valid results and bus timing against it.
module tb_lcd_reader;
  localparam int T_AS     = 3;
  localparam int T_EN     = 25;
  localparam int T_EN_LOW = 25;
  localparam int POLL_MAX = 4;
  localparam int TXN      = T_AS + T_EN + T_EN_LOW;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] data;
    logic       bf;
    logic [6:0] addr;
    logic       to;
    int         reads;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, rs = 1'b0, poll = 1'b0;
  logic [7:0] bus = 8'h00;
  logic       o_busy, o_valid, o_bf, o_timeout, o_LCD_EN, o_LCD_RS, o_LCD_RW;
  logic [7:0] o_data;
  logic [6:0] o_addr;

  int         checks = 0, passed = 0, edge_cnt = 0;
  exp_t       exp_q[$];
  logic [7:0] bus_q[$];
  logic       m_bf = 1'b0;
  logic [6:0] m_addr = '0;
  int         cur_start = 0;
  logic       cur_rs = 1'b0;
  int         en_pulses = 0, en_cnt = 0;
  logic       prev_en = 1'b0;

  lcd_reader #(.T_AS(T_AS), .T_EN(T_EN), .T_EN_LOW(T_EN_LOW), .POLL_MAX(POLL_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rs(rs), .i_poll(poll),
    .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data), .o_bf(o_bf),
    .o_addr(o_addr), .o_timeout(o_timeout), .o_LCD_EN(o_LCD_EN),
    .o_LCD_RS(o_LCD_RS), .o_LCD_RW(o_LCD_RW), .i_LCD_data(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // LCD side: junk on the bus except during the last EN-high cycle of each pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0;
      bus = 8'($urandom);
    end else if (o_LCD_EN) begin
      en_cnt++;
      if (en_cnt == T_EN) begin
        if (bus_q.size() == 0) begin
          checks++;
          $display("FAIL bus_plan: got extra read expected none (t=%0t)", $time);
          bus = 8'($urandom);
        end else bus = bus_q.pop_front();
      end else bus = 8'($urandom);
    end else begin
      if (en_cnt != 0) check("en_width", en_cnt, T_EN);
      en_cnt = 0;
      bus = 8'($urandom);
    end
  end

  // Monitor: pops the scoreboard on every o_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_pulses = 0;
      prev_en = 1'b0;
    end else begin
      if (o_LCD_EN && !prev_en) begin
        if (en_pulses == 0) check("en_rise_latency", edge_cnt - cur_start, T_AS);
        check("lcd_rs", o_LCD_RS, cur_rs);
        check("lcd_rw", o_LCD_RW, 1);
        en_pulses++;
      end
      prev_en = o_LCD_EN;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: got o_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("data", o_data, e.data);
          check("bf", o_bf, e.bf);
          check("addr", o_addr, e.addr);
          check("timeout", o_timeout, e.to);
          check("valid_latency", edge_cnt - cur_start, e.reads * TXN);
          check("en_pulses", en_pulses, e.reads);
          check("busy_in_done", o_busy, 1);
          check("rw_in_done", o_LCD_RW, 0);
        end
        en_pulses = 0;
      end
    end
  end

  // Model: consume plan bytes as the LCD would answer successive reads.
  task automatic issue(input logic r, input logic p, input bq_t plan, input bit from_done,
                       input bit track);
    int n = 0;
    logic [7:0] v;
    exp_t e;
    do begin
      v = (plan.size() != 0) ? plan.pop_front() : 8'($urandom);
      bus_q.push_back(v);
      n++;
    end while (p && !r && v[7] && n < POLL_MAX);
    if (!r) begin
      m_bf = v[7];
      m_addr = v[6:0];
    end
    e.data = v; e.bf = m_bf; e.addr = m_addr; e.to = p & ~r & v[7]; e.reads = n;
    if (track) exp_q.push_back(e);
    if (!from_done) @(negedge clk);
    rs = r; poll = p; start = 1'b1;
    if (from_done) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cur_start = edge_cnt;
    cur_rs = r;
    start = 1'b0;
    rs = 1'($urandom);
    poll = 1'($urandom);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (o_busy && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (o_busy) begin
      checks++;
      $display("FAIL idle_timeout: got o_busy=1 expected 0 (t=%0t)", $time);
    end
  endtask

  task automatic wait_valid();
    int i = 0;
    while (!o_valid && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (!o_valid) begin
      checks++;
      $display("FAIL valid_timeout: got o_valid=0 expected 1 (t=%0t)", $time);
    end
  endtask

  task automatic mid_pulse(input int dly);
    repeat (dly) @(negedge clk);
    if (o_busy) begin
      start = 1'b1;
      rs = 1'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bq_t  q;
    logic r, p;
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_bf", o_bf, 0);
    check("rst_addr", o_addr, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_en", o_LCD_EN, 0);
    check("rst_rw", o_LCD_RW, 0);
    check("rst_rs", o_LCD_RS, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    q = '{8'h45};                 issue(0, 0, q, 0, 1); wait_idle();
    q = '{8'h41};                 issue(1, 0, q, 0, 1); wait_idle();
    q = '{8'hC1};                 issue(1, 1, q, 0, 1); wait_idle();
    q = '{8'h9A, 8'h85, 8'hFF, 8'h10}; issue(0, 1, q, 0, 1); wait_idle();
    q = '{8'h80, 8'h80, 8'h80, 8'h80}; issue(0, 1, q, 0, 1); wait_idle();

    // Starts mid-transaction and in S_DONE are dropped; the one held into S_IDLE is taken.
    q = '{8'h3C};                 issue(0, 0, q, 0, 1);
    mid_pulse(10);
    wait_valid();
    q = '{8'h27};                 issue(0, 0, q, 1, 1); wait_idle();

    for (int t = 0; t < 20; t++) begin
      r = 1'($urandom);
      p = 1'($urandom);
      q.delete();
      for (int j = 0; j < POLL_MAX; j++)
        q.push_back({($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 7'($urandom)});
      issue(r, p, q, 0, 1);
      if ($urandom_range(0, 2) == 0) mid_pulse($urandom_range(1, 45));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of an EN pulse discards the read.
    q = '{8'h55};                 issue(0, 0, q, 0, 0);
    for (int i = 0; i < 100 && !o_LCD_EN; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_en", o_LCD_EN, 0);
    check("rst_mid_rw", o_LCD_RW, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_data", o_data, 0);
    check("rst_mid_addr", o_addr, 0);
    bus_q.delete();
    m_bf = 1'b0;
    m_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    q = '{8'h23};                 issue(0, 0, q, 0, 1); wait_idle();
    repeat (3) @(negedge clk);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
